objline_serializer: RTL and testbench

//  Parametrised successor of the OBJ line latch. Buffers fetched sprite tile lines (pixel word + palette + X + flip)
//  in a small FIFO, serialises each into NLANES pixels per 6 MHz enable cycle and issues per-lane line-buffer writes.

---
 rtl/objline_pkg.sv | 53 +++++
 rtl/objline_serializer_if.sv | 35 +++
 rtl/objline_fifo.sv | 56 +++++
 rtl/objline_serializer.sv | 170 +++++++++++++++++
 tb/tb_objline_serializer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/objline_pkg.sv
// Shared types and helpers for the OBJ line serializer: FSM state encoding,
// a constant clog2, default parameter values and tile-line entry layout.
// An entry is packed as {pixel word, palette, xpos, hflip} with hflip in bit 0.
package objline_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Default geometry
  localparam int PXW_DEF    = 4;
  localparam int NPX_DEF    = 8;
  localparam int PALW_DEF   = 4;
  localparam int XW_DEF     = 9;
  localparam int DEPTH_DEF  = 2;
  localparam int NLANES_DEF = 2;
  localparam int XVIS_DEF   = 256;

  // Entry field layout
  function automatic int entry_w(input int npx, input int pxw, input int palw, input int xw);
    return npx * pxw + palw + xw + 1;
  endfunction

  function automatic int xpos_lsb();
    return 1;
  endfunction

  function automatic int pal_lsb(input int xw);
    return xw + 1;
  endfunction

  function automatic int data_lsb(input int xw, input int palw);
    return xw + palw + 1;
  endfunction

  // Per-lane line-buffer widths
  function automatic int lane_aw(input int xw, input int nlanes);
    return xw - clog2(nlanes);
  endfunction

  function automatic int lane_dw(input int palw, input int pxw);
    return palw + pxw;
  endfunction

endpackage

// File: rtl/objline_serializer_if.sv
// Tile-line input handshake plus multi-lane line-buffer write bus.
// master: tile fetcher / line buffer side; slave: the serializer.
interface objline_serializer_if
  import objline_pkg::*;
#(
  parameter int PXW    = PXW_DEF,
  parameter int NPX    = NPX_DEF,
  parameter int PALW   = PALW_DEF,
  parameter int XW     = XW_DEF,
  parameter int NLANES = NLANES_DEF
);
  localparam int AW = lane_aw(XW, NLANES);
  localparam int DW = lane_dw(PALW, PXW);

  logic                   i_TL_VALID;
  logic                   o_TL_READY;
  logic [NPX*PXW-1:0]     i_TL_DATA;
  logic [PALW-1:0]        i_TL_PAL;
  logic [XW-1:0]          i_TL_XPOS;
  logic                   i_TL_HFLIP;
  logic [NLANES-1:0]      o_LB_WE;
  logic [NLANES*AW-1:0]   o_LB_ADDR;
  logic [NLANES*DW-1:0]   o_LB_DATA;

  modport master (
    output i_TL_VALID, i_TL_DATA, i_TL_PAL, i_TL_XPOS, i_TL_HFLIP,
    input  o_TL_READY, o_LB_WE, o_LB_ADDR, o_LB_DATA
  );

  modport slave (
    input  i_TL_VALID, i_TL_DATA, i_TL_PAL, i_TL_XPOS, i_TL_HFLIP,
    output o_TL_READY, o_LB_WE, o_LB_ADDR, o_LB_DATA
  );

endinterface

// File: rtl/objline_fifo.sv
// Small synchronous FIFO of tile-line entries with occupancy count and flush.
// Read data is presented combinationally from the head slot so the serializer
// can reload its work register on the same edge it finishes a line.
module objline_fifo
  import objline_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;

  // Pointer and occupancy tracking; flush wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset, pointers qualify them
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/objline_serializer.sv
// OBJ tile-line serializer: queues fetched tile lines and writes NLANES pixels
// per 6 MHz enable cycle into a multi-bank line buffer. Pixel code 0 is
// transparent (write strobe suppressed, address/data still driven).
// Optional build macro OBJLINE_XCLIP_EN: drop pixels whose unwrapped X is at or
// beyond XVIS instead of wrapping them around the line.
module objline_serializer
  import objline_pkg::*;
#(
  parameter int PXW    = PXW_DEF,
  parameter int NPX    = NPX_DEF,
  parameter int PALW   = PALW_DEF,
  parameter int XW     = XW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NLANES = NLANES_DEF,
  parameter int XVIS   = XVIS_DEF
) (
  input  logic                  i_EMU_MCLK,
  input  logic                  i_EMU_MRST_n,
  input  logic                  i_EMU_CLK6MPCEN_n,
  input  logic                  i_FLUSH,
  objline_serializer_if.slave   bus,
  output logic                  o_BUSY
);
  localparam int LGL   = clog2(NLANES);
  localparam int AW    = lane_aw(XW, NLANES);
  localparam int DW    = lane_dw(PALW, PXW);
  localparam int EW    = entry_w(NPX, PXW, PALW, XW);
  localparam int NSTEP = NPX / NLANES;
  localparam int SW    = (NSTEP > 1) ? clog2(NSTEP) : 1;

`ifdef OBJLINE_XCLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic en;
  assign en = !i_EMU_CLK6MPCEN_n;

  // FSM and work register
  state_t             state_q;
  logic [SW-1:0]      step_q;
  logic [NPX*PXW-1:0] work_data_q;
  logic [PALW-1:0]    work_pal_q;
  logic [XW-1:0]      work_xpos_q;
  logic               work_hflip_q;

  // Registered line-buffer outputs
  logic [NLANES-1:0]    we_q;
  logic [NLANES*AW-1:0] addr_q;
  logic [NLANES*DW-1:0] data_q;

  // FIFO hookup
  logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [EW-1:0] fifo_wdata, fifo_rdata;
  logic          last_step;

  assign last_step  = (state_q == RUN) && (step_q == SW'(NSTEP - 1));
  assign fifo_flush = en && i_FLUSH;
  assign fifo_push  = en && !i_FLUSH && bus.i_TL_VALID && !fifo_full;
  assign fifo_pop   = en && !i_FLUSH && !fifo_empty && ((state_q == IDLE) || last_step);
  assign fifo_wdata = {bus.i_TL_DATA, bus.i_TL_PAL, bus.i_TL_XPOS, bus.i_TL_HFLIP};

  objline_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (i_EMU_MCLK),
    .rst_n   (i_EMU_MRST_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Per-lane pixel selection for the current step. Pixels of one step sit at
  // consecutive X, so lane gi receives the pixel whose offset within the step
  // is (gi - xpos) mod NLANES.
  logic [NLANES-1:0]    lane_we;
  logic [NLANES*AW-1:0] lane_addr;
  logic [NLANES*DW-1:0] lane_data;

  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : g_lane
      int           k;
      int           i_idx;
      int           j;
      logic [XW:0]  xsum;
      logic [PXW-1:0] pix;

      // Locate this lane's pixel, its unwrapped X and its (possibly mirrored) code
      always_comb begin
        k     = (gi - int'(work_xpos_q)) & (NLANES - 1);
        i_idx = int'(step_q) * NLANES + k;
        j     = work_hflip_q ? (NPX - 1 - i_idx) : i_idx;
        xsum  = {1'b0, work_xpos_q} + (XW+1)'(i_idx);
        pix   = work_data_q[(NPX - 1 - j) * PXW +: PXW];
      end

      assign lane_we[gi]              = (pix != '0) && (!CLIP_EN || (int'(xsum) < XVIS));
      assign lane_addr[gi*AW +: AW]   = AW'(xsum[XW-1:0] >> LGL);
      assign lane_data[gi*DW +: DW]   = {work_pal_q, pix};
    end
  endgenerate

  // Serializer FSM: load a line, emit one step per enable, chain lines without a bubble
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      state_q      <= IDLE;
      step_q       <= '0;
      work_data_q  <= '0;
      work_pal_q   <= '0;
      work_xpos_q  <= '0;
      work_hflip_q <= 1'b0;
      we_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
    end else if (en) begin
      if (i_FLUSH) begin
        state_q <= IDLE;
        step_q  <= '0;
        we_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            we_q <= '0;
            if (!fifo_empty) begin
              work_data_q  <= fifo_rdata[EW-1 -: NPX*PXW];
              work_pal_q   <= fifo_rdata[pal_lsb(XW) +: PALW];
              work_xpos_q  <= fifo_rdata[xpos_lsb() +: XW];
              work_hflip_q <= fifo_rdata[0];
              step_q       <= '0;
              state_q      <= RUN;
            end
          end
          RUN: begin
            we_q   <= lane_we;
            addr_q <= lane_addr;
            data_q <= lane_data;
            if (last_step) begin
              if (!fifo_empty) begin
                work_data_q  <= fifo_rdata[EW-1 -: NPX*PXW];
                work_pal_q   <= fifo_rdata[pal_lsb(XW) +: PALW];
                work_xpos_q  <= fifo_rdata[xpos_lsb() +: XW];
                work_hflip_q <= fifo_rdata[0];
                step_q       <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_TL_READY = !fifo_full;
  assign bus.o_LB_WE    = we_q;
  assign bus.o_LB_ADDR  = addr_q;
  assign bus.o_LB_DATA  = data_q;
  assign o_BUSY         = !fifo_empty || (state_q == RUN);

endmodule

// File: tb/tb_objline_serializer.sv
// Scoreboard bench for objline_serializer (default geometry: 2 lanes, 8 px).
// Stimulus pushes hand-computed expected write steps {we, addr1, addr0,
// data1, data0} into a queue; a monitor pops one per enabled write cycle.
module tb_objline_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen_n = 1'b0;
  logic flush = 1'b0;
  logic busy;

  objline_serializer_if bus ();

  objline_serializer dut (
    .i_EMU_MCLK        (clk),
    .i_EMU_MRST_n      (rst_n),
    .i_EMU_CLK6MPCEN_n (cen_n),
    .i_FLUSH           (flush),
    .bus               (bus),
    .o_BUSY            (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  int last_push_cyc = 0;
  logic [33:0] sb[$];
  int wr_cycles[$];
  logic mon_en;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [33:0] mk(input logic [1:0] we, input logic [7:0] a1, input logic [7:0] a0,
                                     input logic [7:0] d1, input logic [7:0] d0);
    return {we, a1, a0, d1, d0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: one comparison per enabled edge that produced a write
  initial begin
    logic [33:0] act, exp;
    forever begin
      @(posedge clk);
      mon_en = !cen_n && rst_n;
      @(negedge clk);
      if (mon_en && bus.o_LB_WE != 2'b00) begin
        act = {bus.o_LB_WE, bus.o_LB_ADDR, bus.o_LB_DATA};
        wr_cycles.push_back(cycle);
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL lb_write act=%0h exp=none (unexpected write)", act);
        end else begin
          exp = sb.pop_front();
          if (act !== exp) begin
            n_fail++;
            $display("FAIL lb_write act=%0h exp=%0h", act, exp);
          end else begin
            $display("[TB] write cyc=%0d we=%b addr=%h data=%h ok", cycle, bus.o_LB_WE, bus.o_LB_ADDR, bus.o_LB_DATA);
          end
        end
      end
    end
  end

  task automatic push(input logic [31:0] d, input logic [3:0] p, input logic [8:0] x, input logic f);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.o_TL_READY && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.o_TL_READY) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_wait act=ready0 exp=ready1");
    end
    bus.i_TL_DATA  = d;
    bus.i_TL_PAL   = p;
    bus.i_TL_XPOS  = x;
    bus.i_TL_HFLIP = f;
    bus.i_TL_VALID = 1'b1;
    @(posedge clk);
    #1;
    bus.i_TL_VALID = 1'b0;
    last_push_cyc = cycle;
    $display("[TB] push cyc=%0d data=%h pal=%h x=%0d flip=%b", cycle, d, p, x, f);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || bus.o_LB_WE != 2'b00) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_idle"}, {busy, bus.o_LB_WE}, 3'b000);
    chk({name, "_drain"}, sb.size(), 0);
  endtask

  task automatic wait_writes(input int n);
    int t;
    t = 0;
    while (wr_cycles.size() < n && t < 50) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("wr_wait", wr_cycles.size() >= n, 1);
  endtask

  // Expected step sequences
  task automatic exp_t1();  // 12345678, pal A, X=10, no flip
    sb.push_back(mk(2'b11, 8'h05, 8'h05, 8'hA2, 8'hA1));
    sb.push_back(mk(2'b11, 8'h06, 8'h06, 8'hA4, 8'hA3));
    sb.push_back(mk(2'b11, 8'h07, 8'h07, 8'hA6, 8'hA5));
    sb.push_back(mk(2'b11, 8'h08, 8'h08, 8'hA8, 8'hA7));
  endtask

  task automatic exp_t2();  // 12345678, pal A, X=11, flip
    sb.push_back(mk(2'b11, 8'h05, 8'h06, 8'hA8, 8'hA7));
    sb.push_back(mk(2'b11, 8'h06, 8'h07, 8'hA6, 8'hA5));
    sb.push_back(mk(2'b11, 8'h07, 8'h08, 8'hA4, 8'hA3));
    sb.push_back(mk(2'b11, 8'h08, 8'h09, 8'hA2, 8'hA1));
  endtask

  task automatic exp_t3(input int nsteps);  // 10203040, pal A, X=0, no flip
    if (nsteps > 0) sb.push_back(mk(2'b01, 8'h00, 8'h00, 8'hA0, 8'hA1));
    if (nsteps > 1) sb.push_back(mk(2'b01, 8'h01, 8'h01, 8'hA0, 8'hA2));
    if (nsteps > 2) sb.push_back(mk(2'b01, 8'h02, 8'h02, 8'hA0, 8'hA3));
    if (nsteps > 3) sb.push_back(mk(2'b01, 8'h03, 8'h03, 8'hA0, 8'hA4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] held;
    bus.i_TL_VALID = 1'b0;
    bus.i_TL_DATA  = '0;
    bus.i_TL_PAL   = '0;
    bus.i_TL_XPOS  = '0;
    bus.i_TL_HFLIP = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_lb", {bus.o_LB_WE, bus.o_LB_ADDR, bus.o_LB_DATA}, 34'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", bus.o_TL_READY, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: basic line, latency push->first write = 2 enabled edges
    wr_cycles.delete();
    exp_t1();
    push(32'h1234_5678, 4'hA, 9'd10, 1'b0);
    wait_idle("t1");
    chk("t1_latency", wr_cycles[0] - last_push_cyc, 2);
    chk("t1_nwr", wr_cycles.size(), 4);

    // T2: mirrored line, with enable held high for 3 clocks mid-line
    wr_cycles.delete();
    exp_t2();
    push(32'h1234_5678, 4'hA, 9'd11, 1'b1);
    wait_writes(2);
    held = {bus.o_LB_WE, bus.o_LB_ADDR, bus.o_LB_DATA};
    cen_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t2_hold", {bus.o_LB_WE, bus.o_LB_ADDR, bus.o_LB_DATA}, held);
    chk("t2_hold_busy", busy, 1'b1);
    cen_n = 1'b0;
    wait_idle("t2");

    // T3: transparent pixels suppress lane 1
    exp_t3(4);
    push(32'h1020_3040, 4'hA, 9'd0, 1'b0);
    wait_idle("t3");

    // T4: three back-to-back entries -> FIFO full, 12 writes with no bubble
    wr_cycles.delete();
    exp_t1();
    exp_t2();
    exp_t3(4);
    push(32'h1234_5678, 4'hA, 9'd10, 1'b0);
    push(32'h1234_5678, 4'hA, 9'd11, 1'b1);
    push(32'h1020_3040, 4'hA, 9'd0, 1'b0);
    chk("t4_ready_full", bus.o_TL_READY, 1'b0);
    wait_idle("t4");
    chk("t4_nwr", wr_cycles.size(), 12);
    chk("t4_span", wr_cycles[wr_cycles.size()-1] - wr_cycles[0], 11);

    // T5: X near the end of the line
    wr_cycles.delete();
`ifndef OBJLINE_XCLIP_EN
    sb.push_back(mk(2'b11, 8'hFF, 8'hFF, 8'hA2, 8'hA1));
    sb.push_back(mk(2'b11, 8'h00, 8'h00, 8'hA4, 8'hA3));
    sb.push_back(mk(2'b11, 8'h01, 8'h01, 8'hA6, 8'hA5));
    sb.push_back(mk(2'b11, 8'h02, 8'h02, 8'hA8, 8'hA7));
`endif
    push(32'h1234_5678, 4'hA, 9'd510, 1'b0);
    wait_idle("t5");
`ifdef OBJLINE_XCLIP_EN
    chk("t5_nwr", wr_cycles.size(), 0);
`else
    chk("t5_nwr", wr_cycles.size(), 4);
`endif

    // T6: flush after step 2 with one entry queued; same-cycle push dropped
    exp_t3(3);
    push(32'h1020_3040, 4'hA, 9'd0, 1'b0);
    push(32'h1234_5678, 4'hA, 9'd10, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    bus.i_TL_DATA  = 32'h1234_5678;
    bus.i_TL_XPOS  = 9'd10;
    bus.i_TL_VALID = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.i_TL_VALID = 1'b0;
    @(negedge clk);
    chk("t6_we", bus.o_LB_WE, 2'b00);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", bus.o_TL_READY, 1'b1);
    chk("t6_drain", sb.size(), 0);
    repeat (6) @(negedge clk);
    chk("t6_still_idle", busy, 1'b0);

    // T7: asynchronous reset mid-line
    exp_t1();
    push(32'h1234_5678, 4'hA, 9'd10, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_lb", {bus.o_LB_WE, bus.o_LB_ADDR, bus.o_LB_DATA}, 34'h0);
    chk("t7_busy", busy, 1'b0);
    chk("t7_ready", bus.o_TL_READY, 1'b1);
    chk("t7_two_written", sb.size(), 2);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t7_after", {busy, bus.o_LB_WE}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
